tinyalu_result_collector: RTL
=============================

# tinyalu_result_collector

Synthesizable pin-level collector that sits between the TinyALU DUT pins and the result-consuming stage. It watches the command/response protocol, pairs each accepted command (op, A, B) with its result, and flags protocol faults (timeout, early start drop). It queues completed transactions in a small FIFO and presents them downstream over a valid/ready handshake, from which the result-printing stage builds alu_result objects.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TIMEOUT, 16: max cycles in WAIT before a timeout entry is pushed; ≥4.

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  DUT start pin.
- op  in  3  DUT op pin. 0=no_op, 1=add, 2=and, 3=xor, 4=mul, 5-7 illegal.
- A  in  8  DUT operand A.
- B  in  8  DUT operand B.
- done  in  1  DUT done pin.
- result  in  16  DUT result pin.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts head entry.
- out_op  out  3  head op.
- out_a  out  8  head A.
- out_b  out  8  head B.
- out_result  out  16  head result (0 on fault).
- out_status  out  2  00 ok, 01 timeout, 10 start dropped before done.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.
- overflow  out  1  sticky: an entry was dropped because the FIFO was full.
- spurious_done  out  1  sticky: done seen high while IDLE.

## Operation
- Registers start_q (previous start), FSM {IDLE, WAIT}, cmd latch {op,A,B}, cycle counter, FIFO.
- Command acceptance: IDLE and start & !start_q and op in 1..4 → latch op/A/B, clear counter, go to WAIT. Rising start with op 0 or 5-7 → ignored, stays IDLE.
- IDLE: done high → set spurious_done. Nothing pushed.
- WAIT, evaluated each edge in priority order:
  1. done high → push {cmd, result, 00}, go to IDLE.
  2. start low → push {cmd, 0, 10}, go to IDLE.
  3. counter == TIMEOUT-1 → push {cmd, 0, 01}, go to IDLE.
  4. else counter+1.
- Return to IDLE needs a fresh start rising edge. A start held high after done starts no second command.
- FIFO: push at write pointer, pop when out_valid & out_ready. Head data is driven combinationally from the read pointer. Pointers wrap modulo DEPTH.
- Push while full and no pop → entry discarded, overflow set.
- Push and pop on the same edge while full → both occur, no overflow, count unchanged.
- Push and pop on the same edge while empty is impossible, because pop needs out_valid.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, start_q=0, counter=0, FIFO empty.
- Output values in reset: out_valid=0, fifo_count=0, overflow=0, spurious_done=0, out_op/out_a/out_b/out_result/out_status=0.
- start_q resets to 0, so a start already high at reset release counts as a rising edge on the first clock.
- Acceptance edge E0: state=WAIT after E0.
- done sampled high at edge En: entry written at En; out_valid=1 and fifo_count incremented in the cycle after En.
- Done-to-out_valid latency is 1 clock.
- Fastest DUT op (1-cycle add) sees done at E1: the entry is available after E1.
- mul sees done at E3.
- Timeout: with no done, push at edge E(TIMEOUT) counting from acceptance E0. done high on that same edge wins (status 00).
- done and start-low on the same edge → status 00.
- Pop takes effect at the clock edge; the new head is visible the next cycle.
- Reset asserted in WAIT: the pending command is lost and no entry is pushed. The FIFO contents are lost.

## Test plan
- add A=0x05 B=0x03, done+result=0x0008 one cycle after acceptance, out_ready=1 → one entry op=1,a=05,b=03,result=0008,status=00; out_valid high exactly 1 cycle.
- mul A=0xFF B=0xFF, done at E3 with 0xFE01 → entry result=FE01,status=00; start held high 3 more cycles → no second entry.
- and A=0xAA B=0x0F, start held, done never → status=01 entry pushed at E16, result=0000. Repeat with done at E16 → status=00.
- out_ready=0, five back-to-back xor commands → fifo_count=4, overflow=1, entries 1-4 in order, fifth lost. Then a sixth command completing on the same edge as a pop → count stays 4, overflow unchanged, sixth entry present.
- Reset pulse mid-WAIT of a mul, then done pulse in IDLE → fifo_count=0, no entry, spurious_done=1. Start with op=0 → no acceptance.
- start dropped at E2 of a mul → entry status=10, result=0000.

Source files
------------

// File: rtl/tinyalu_result_collector.sv
// rtl/tinyalu_result_collector.sv - pairs TinyALU commands with results and queues them for a valid/ready consumer
module tinyalu_result_collector #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [2:0]                 op,
   input  logic [7:0]                 A,
   input  logic [7:0]                 B,
   input  logic                       done,
   input  logic [15:0]                result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2:0]                 out_op,
   output logic [7:0]                 out_a,
   output logic [7:0]                 out_b,
   output logic [15:0]                out_result,
   output logic [1:0]                 out_status,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       overflow,
   output logic                       spurious_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state;
   logic            start_q;
   logic [2:0]      cmd_op;
   logic [7:0]      cmd_a;
   logic [7:0]      cmd_b;
   logic [TW-1:0]   counter;

   logic [36:0]     mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   count;

   logic            accept;
   logic            push;
   logic            pop;
   logic            full;
   logic            write;
   logic [15:0]     push_result;
   logic [1:0]      push_status;
   logic [36:0]     head;

   assign accept = (state == IDLE) && start && !start_q && (op >= 3'd1) && (op <= 3'd4);

   // Terminating conditions in WAIT, highest priority first: done beats start-drop beats timeout.
   always_comb begin
      push        = 1'b0;
      push_result = 16'h0000;
      push_status = 2'b00;
      if (state == WAIT) begin
         if (done) begin
            push        = 1'b1;
            push_result = result;
         end else if (!start) begin
            push        = 1'b1;
            push_status = 2'b10;
         end else if (counter == TW'(TIMEOUT - 1)) begin
            push        = 1'b1;
            push_status = 2'b01;
         end
      end
   end

   assign out_valid  = (count != '0);
   assign full       = (count == CW'(DEPTH));
   assign pop        = out_valid && out_ready;
   assign write      = push && (!full || pop);
   assign fifo_count = count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         start_q       <= 1'b0;
         cmd_op        <= 3'd0;
         cmd_a         <= 8'h00;
         cmd_b         <= 8'h00;
         counter       <= '0;
         spurious_done <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (done)
                  spurious_done <= 1'b1;
               if (accept) begin
                  cmd_op  <= op;
                  cmd_a   <= A;
                  cmd_b   <= B;
                  counter <= '0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (push)
                  state <= IDLE;
               else
                  counter <= counter + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (write)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         count <= count + CW'(write) - CW'(pop);
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (write)
         mem[wptr] <= {cmd_op, cmd_a, cmd_b, push_result, push_status};
   end

   // Storage is not reset, so the head is forced to zero while the queue is empty.
   assign head = out_valid ? mem[rptr] : 37'd0;
   assign {out_op, out_a, out_b, out_result, out_status} = head;

endmodule
